// File: rtl/eeprom_page_sched.sv
// Purpose : round-robin scheduler sharing one I2C EEPROM page-write engine among
//           NREQ requesters; splits each {addr,len} request into page-aligned chunks.
// Latency : req seen in IDLE -> first o_eng_start 2 cycles later; o_eng_done ->
//           next o_eng_start exactly TWR_CYC+1 cycles; len==0 -> o_done 2 cycles.
// Backpressure: o_eng_start is held off while i_eng_busy is high; requests wait at
//           their level until granted and completed.
// Ports   : i_clk/i_rst (async, active-high); i_req/i_req_addr/i_req_len per
//           requester; o_grant one-hot owner; o_done/o_err completion pulses;
//           o_eng_start/o_eng_addr/o_eng_len chunk command; i_eng_busy/i_eng_done/
//           i_eng_nack engine status.
// Config  : define EEPROM_SCHED_RETRY_EN to re-issue NACKed chunks up to MAX_RETRY
//           times; without it the first NACK ends the request with o_err.
module eeprom_page_sched #(
  parameter int NREQ      = 2,
  parameter int AW        = 13,
  parameter int LW        = 9,
  parameter int PAGE      = 32,
  parameter int TWR_CYC   = 2000,
  parameter int MAX_RETRY = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*AW-1:0] i_req_addr,
  input  logic [NREQ*LW-1:0] i_req_len,
  output logic [NREQ-1:0]    o_grant,
  output logic [NREQ-1:0]    o_done,
  output logic               o_err,
  output logic               o_eng_start,
  output logic [AW-1:0]      o_eng_addr,
  output logic [LW-1:0]      o_eng_len,
  input  logic               i_eng_busy,
  input  logic               i_eng_done,
  input  logic               i_eng_nack
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PB = $clog2(PAGE);
  localparam int CW = $clog2(TWR_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_ISSUE, S_WAIT, S_TWR, S_FIN} state_t;

  state_t          r_state, w_next;
  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] r_grant;
  logic [AW-1:0]   r_addr;
  logic [LW-1:0]   r_rem;
  logic [CW-1:0]   r_cnt;
  logic            r_nack;
  logic            r_err;

  logic [PW-1:0]   w_idx, w_win, w_ptr_nxt;
  logic            w_found;
  logic [AW-1:0]   w_sel_addr;
  logic [LW-1:0]   w_sel_len;
  logic [LW-1:0]   w_room, w_chunk;
  logic            w_twr_end;
  logic            w_retry_ok;

`ifdef EEPROM_SCHED_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] r_retry;
  assign w_retry_ok = (r_retry < RW'(MAX_RETRY));
`else
  assign w_retry_ok = 1'b0;
`endif

  // Round-robin: first active request at or after r_ptr, wrapping.
  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_idx      = '0;
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = PW'((int'(r_ptr) + i) % NREQ);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == PW'(i)) begin
        w_sel_addr = i_req_addr[i*AW +: AW];
        w_sel_len  = i_req_len[i*LW +: LW];
      end
    end
  end

  assign w_ptr_nxt = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;

  // Chunk never crosses a page: bounded by bytes left in the current page.
  assign w_room    = LW'(PAGE) - LW'(r_addr[PB-1:0]);
  assign w_chunk   = (r_rem < w_room) ? r_rem : w_room;
  assign w_twr_end = (r_cnt == CW'(TWR_CYC - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_eng_start = 1'b0;
    case (r_state)
      S_IDLE:  if (|i_req) w_next = S_ARB;
      S_ARB: begin
        if (!w_found)              w_next = S_IDLE;   // request withdrawn before arbitration
        else if (w_sel_len == '0)  w_next = S_FIN;
        else                       w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (!i_eng_busy) begin
          o_eng_start = 1'b1;
          w_next      = S_WAIT;
        end
      end
      S_WAIT:  if (i_eng_done) w_next = S_TWR;
      S_TWR: begin
        if (w_twr_end) begin
          if (r_nack)                w_next = w_retry_ok ? S_ISSUE : S_FIN;
          else if (r_rem == w_chunk) w_next = S_FIN;
          else                       w_next = S_ISSUE;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_addr  <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_nack  <= 1'b0;
      r_err   <= 1'b0;
`ifdef EEPROM_SCHED_RETRY_EN
      r_retry <= '0;
`endif
    end else begin
      case (r_state)
        S_ARB: begin
          if (w_found) begin
            r_grant <= NREQ'(1) << w_win;
            r_addr  <= w_sel_addr;
            r_rem   <= w_sel_len;
            r_ptr   <= w_ptr_nxt;
            r_err   <= 1'b0;
`ifdef EEPROM_SCHED_RETRY_EN
            r_retry <= '0;
`endif
          end
        end
        S_WAIT: begin
          r_cnt <= '0;
          if (i_eng_done) r_nack <= i_eng_nack;
        end
        S_TWR: begin
          if (w_twr_end) begin
            r_cnt <= '0;
            if (r_nack) begin
`ifdef EEPROM_SCHED_RETRY_EN
              if (w_retry_ok) r_retry <= r_retry + 1'b1;
              else            r_err   <= 1'b1;
`else
              r_err <= 1'b1;
`endif
            end else begin
              // Address wraps naturally at 2^AW.
              r_addr <= r_addr + AW'(w_chunk);
              r_rem  <= r_rem - w_chunk;
`ifdef EEPROM_SCHED_RETRY_EN
              r_retry <= '0;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIN:   r_grant <= '0;
        default: ;
      endcase
    end
  end

  assign o_grant    = r_grant;
  assign o_done     = (r_state == S_FIN) ? r_grant : '0;
  assign o_err      = (r_state == S_FIN) && r_err;
  assign o_eng_addr = r_addr;
  assign o_eng_len  = w_chunk;

endmodule
